// File: rtl/handshake_pkg.sv
// Shared types and default parameter values for the 4-phase handshake receiver
// with its internal first-word-fall-through buffer.
package handshake_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_SPACE   = 2'd1,
    LATCH        = 2'd2,
    WAIT_REQ_LOW = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_CNT_WIDTH   = 16;

endpackage

// File: rtl/hs_fifo_fwft.sv
// First-word-fall-through FIFO: head is valid combinationally from storage,
// level and full are registered. DEPTH must be a power of two.
module hs_fifo_fwft
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  full_q, full_d;
  logic                  do_push, do_pop;

  assign valid   = (level_q != '0);
  assign do_push = push && !full_q;
  assign do_pop  = pop && valid;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_W'(DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by level_q and head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = valid ? mem_q[rd_ptr_q] : '0;
  assign level = level_q;
  assign full  = full_q;

endmodule

// File: rtl/handshake_receiver_fifo.sv
// 4-phase req/ack receiver synchronised into clk_fpga, buffering words in a
// FWFT FIFO with valid/ready output, ack backpressure and a sticky timeout flag.
module handshake_receiver_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   clk_fpga,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_dados,
  input  logic                   i_req,
  output logic                   o_ack,
  output logic [DATA_WIDTH-1:0]  o_dados,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_nivel,
  output logic                   o_cheio,
  output logic                   o_novo_dado_pronto,
  output logic [CNT_WIDTH-1:0]   o_num_transf,
  output logic                   o_erro_timeout,
  input  logic                   i_limpa_erro
);

  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int TMO_W    = (TMO_LAST < 2) ? 1 : $clog2(TMO_LAST + 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic                   novo_q, novo_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   erro_q, erro_d;
  logic                   req_s, push, full, tmo_at_limit, tmo_hit;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_req};
  assign req_s  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (req_s) state_d = full ? WAIT_SPACE : LATCH;
      WAIT_SPACE:   if (!full) state_d = LATCH;
      LATCH:        state_d = WAIT_REQ_LOW;
      WAIT_REQ_LOW: if (!req_s) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // LATCH is only reachable from IDLE/WAIT_SPACE, so this marks the entering edge.
  assign push         = (state_d == LATCH);
  assign tmo_at_limit = (tmo_cnt_q == TMO_W'(TMO_LAST));
  assign tmo_hit      = (TIMEOUT_CYC > 0) && (state_q == WAIT_REQ_LOW) && tmo_at_limit;

  always_comb begin
    ack_d     = ack_q;
    novo_d    = push;
    num_d     = num_q + CNT_WIDTH'(push);
    tmo_cnt_d = tmo_cnt_q;
    erro_d    = erro_q;
    if (push) ack_d = 1'b1;
    else if (state_q == WAIT_REQ_LOW && !req_s) ack_d = 1'b0;
    if (state_q == LATCH) tmo_cnt_d = '0;
    else if (state_q == WAIT_REQ_LOW && !tmo_at_limit) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    // Set has priority over a clear in the same cycle.
    if (i_limpa_erro) erro_d = 1'b0;
    if (tmo_hit)      erro_d = 1'b1;
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      ack_q     <= 1'b0;
      novo_q    <= 1'b0;
      num_q     <= '0;
      tmo_cnt_q <= '0;
      erro_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      ack_q     <= ack_d;
      novo_q    <= novo_d;
      num_q     <= num_d;
      tmo_cnt_q <= tmo_cnt_d;
      erro_q    <= erro_d;
    end
  end

  hs_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk_fpga),
    .rst   (reset),
    .push  (push),
    .din   (i_dados),
    .pop   (i_ready),
    .head  (o_dados),
    .valid (o_valid),
    .level (o_nivel),
    .full  (full)
  );

  assign o_cheio            = full;
  assign o_ack              = ack_q;
  assign o_novo_dado_pronto = novo_q;
  assign o_num_transf       = num_q;
  assign o_erro_timeout     = erro_q;

endmodule

// File: tb/tb_handshake_receiver_fifo.sv
// Directed bench for handshake_receiver_fifo: DEPTH=4, SYNC_STAGES=2,
// TIMEOUT_CYC=8, CNT_WIDTH=4 so timeout and counter wrap are reachable quickly.
module tb_handshake_receiver_fifo;

  logic       clk_fpga = 1'b0;
  logic       reset;
  logic [7:0] i_dados;
  logic       i_req;
  logic       o_ack;
  logic [7:0] o_dados;
  logic       o_valid;
  logic       i_ready;
  logic [2:0] o_nivel;
  logic       o_cheio;
  logic       o_novo_dado_pronto;
  logic [3:0] o_num_transf;
  logic       o_erro_timeout;
  logic       i_limpa_erro;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [3:0] exp_num = '0;

  handshake_receiver_fifo #(
    .DATA_WIDTH  (8),
    .DEPTH       (4),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (8),
    .CNT_WIDTH   (4)
  ) dut (
    .clk_fpga           (clk_fpga),
    .reset              (reset),
    .i_dados            (i_dados),
    .i_req              (i_req),
    .o_ack              (o_ack),
    .o_dados            (o_dados),
    .o_valid            (o_valid),
    .i_ready            (i_ready),
    .o_nivel            (o_nivel),
    .o_cheio            (o_cheio),
    .o_novo_dado_pronto (o_novo_dado_pronto),
    .o_num_transf       (o_num_transf),
    .o_erro_timeout     (o_erro_timeout),
    .i_limpa_erro       (i_limpa_erro)
  );

  always #5 clk_fpga = ~clk_fpga;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (o_ack !== lvl && n < 20) begin
      tick();
      n++;
    end
    n_total++;
    if (o_ack !== lvl) $display("FAIL %s: o_ack=%b required %b within 20 cycles", tag, o_ack, lvl);
    else n_pass++;
  endtask

  task automatic send_word(input logic [7:0] d);
    i_dados = d;
    i_req   = 1'b1;
    wait_ack(1'b1, "send_ack_rise");
    exp_num++;
    i_req = 1'b0;
    wait_ack(1'b0, "send_ack_fall");
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b0; i_dados = 8'hFF; i_ready = 1'b0; i_limpa_erro = 1'b0;
    tick(); tick();
    n_total++;
    if ({o_ack, o_valid, o_cheio, o_novo_dado_pronto, o_erro_timeout} !== 5'b0 ||
        o_dados !== 8'h00 || o_nivel !== 3'd0 || o_num_transf !== 4'd0)
      $display("FAIL reset_outputs: ack=%b valid=%b cheio=%b novo=%b erro=%b dados=%h nivel=%0d num=%0d required all 0",
               o_ack, o_valid, o_cheio, o_novo_dado_pronto, o_erro_timeout, o_dados, o_nivel, o_num_transf);
    else n_pass++;
    reset = 1'b0;
    exp_num = '0;
    tick();
  endtask

  task automatic test_single();
    i_dados = 8'hA5; i_req = 1'b1;
    tick(); tick();
    n_total++; if (o_ack !== 1'b0) $display("FAIL t1_ack_early: o_ack=%b required 0 after edge 2", o_ack); else n_pass++;
    tick();
    exp_num++;
    n_total++; if (o_ack !== 1'b1) $display("FAIL t1_ack: o_ack=%b required 1 after edge 3", o_ack); else n_pass++;
    n_total++; if (o_valid !== 1'b1 || o_dados !== 8'hA5) $display("FAIL t1_head: valid=%b dados=%h required 1/a5", o_valid, o_dados); else n_pass++;
    n_total++; if (o_novo_dado_pronto !== 1'b1) $display("FAIL t1_novo: got %b required 1", o_novo_dado_pronto); else n_pass++;
    n_total++; if (o_num_transf !== exp_num || o_nivel !== 3'd1) $display("FAIL t1_counts: num=%0d nivel=%0d required %0d/1", o_num_transf, o_nivel, exp_num); else n_pass++;
    tick();
    n_total++; if (o_novo_dado_pronto !== 1'b0) $display("FAIL t1_novo_pulse: got %b required 0", o_novo_dado_pronto); else n_pass++;
    i_req = 1'b0;
    tick(); tick();
    n_total++; if (o_ack !== 1'b1) $display("FAIL t1_ack_hold: o_ack=%b required 1 two edges after drop", o_ack); else n_pass++;
    tick();
    n_total++; if (o_ack !== 1'b0) $display("FAIL t1_ack_fall: o_ack=%b required 0 three edges after drop", o_ack); else n_pass++;
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    n_total++; if (o_valid !== 1'b0 || o_nivel !== 3'd0 || o_dados !== 8'h00) $display("FAIL t1_pop: valid=%b nivel=%0d dados=%h required 0/0/00", o_valid, o_nivel, o_dados); else n_pass++;
    n_total++; if (o_erro_timeout !== 1'b0) $display("FAIL t1_no_timeout: got %b required 0", o_erro_timeout); else n_pass++;
  endtask

  task automatic test_burst_backpressure();
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_word(8'(k));
    n_total++; if (o_nivel !== 3'd4 || o_cheio !== 1'b1) $display("FAIL t2_full: nivel=%0d cheio=%b required 4/1", o_nivel, o_cheio); else n_pass++;
    n_total++; if (o_dados !== 8'h01) $display("FAIL t2_head: dados=%h required 01", o_dados); else n_pass++;
    i_dados = 8'h05; i_req = 1'b1;
    repeat (6) tick();
    n_total++; if (o_ack !== 1'b0 || o_nivel !== 3'd4) $display("FAIL t2_held: ack=%b nivel=%0d required 0/4", o_ack, o_nivel); else n_pass++;
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    n_total++; if (o_dados !== 8'h02 || o_nivel !== 3'd3 || o_cheio !== 1'b0 || o_ack !== 1'b0)
      $display("FAIL t2_pop: dados=%h nivel=%0d cheio=%b ack=%b required 02/3/0/0", o_dados, o_nivel, o_cheio, o_ack); else n_pass++;
    tick();
    exp_num++;
    n_total++; if (o_ack !== 1'b1 || o_nivel !== 3'd4 || o_cheio !== 1'b1 || o_novo_dado_pronto !== 1'b1)
      $display("FAIL t2_fifth: ack=%b nivel=%0d cheio=%b novo=%b required 1/4/1/1", o_ack, o_nivel, o_cheio, o_novo_dado_pronto); else n_pass++;
    i_req = 1'b0;
    wait_ack(1'b0, "t2_ack_fall");
    i_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      n_total++; if (o_valid !== 1'b1 || o_dados !== 8'(k)) $display("FAIL t2_drain: valid=%b dados=%h required 1/%h", o_valid, o_dados, 8'(k)); else n_pass++;
      tick();
    end
    i_ready = 1'b0;
    n_total++; if (o_valid !== 1'b0 || o_num_transf !== exp_num) $display("FAIL t2_empty: valid=%b num=%0d required 0/%0d", o_valid, o_num_transf, exp_num); else n_pass++;
  endtask

  task automatic test_push_pop_same_cycle();
    send_word(8'h10);
    send_word(8'h11);
    i_dados = 8'h12; i_req = 1'b1;
    tick(); tick();
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    exp_num++;
    n_total++; if (o_nivel !== 3'd2 || o_dados !== 8'h11 || o_ack !== 1'b1)
      $display("FAIL t3_push_pop: nivel=%0d dados=%h ack=%b required 2/11/1", o_nivel, o_dados, o_ack); else n_pass++;
    i_req = 1'b0;
    wait_ack(1'b0, "t3_ack_fall");
    i_ready = 1'b1;
    n_total++; if (o_dados !== 8'h11) $display("FAIL t3_order0: dados=%h required 11", o_dados); else n_pass++;
    tick();
    n_total++; if (o_dados !== 8'h12) $display("FAIL t3_order1: dados=%h required 12", o_dados); else n_pass++;
    tick();
    i_ready = 1'b0;
    n_total++; if (o_valid !== 1'b0) $display("FAIL t3_empty: valid=%b required 0", o_valid); else n_pass++;
  endtask

  task automatic test_timeout();
    i_dados = 8'h20; i_req = 1'b1;
    tick(); tick(); tick();
    exp_num++;
    n_total++; if (o_ack !== 1'b1) $display("FAIL t4_ack: o_ack=%b required 1", o_ack); else n_pass++;
    repeat (8) tick();
    n_total++; if (o_erro_timeout !== 1'b0) $display("FAIL t4_early: erro=%b required 0 after 7 cycles", o_erro_timeout); else n_pass++;
    tick();
    n_total++; if (o_erro_timeout !== 1'b1 || o_ack !== 1'b1) $display("FAIL t4_set: erro=%b ack=%b required 1/1", o_erro_timeout, o_ack); else n_pass++;
    i_limpa_erro = 1'b1; tick(); i_limpa_erro = 1'b0;
    n_total++; if (o_erro_timeout !== 1'b1) $display("FAIL t4_set_wins: erro=%b required 1", o_erro_timeout); else n_pass++;
    i_req = 1'b0;
    wait_ack(1'b0, "t4_ack_fall");
    n_total++; if (o_erro_timeout !== 1'b1) $display("FAIL t4_sticky: erro=%b required 1", o_erro_timeout); else n_pass++;
    i_limpa_erro = 1'b1; tick(); i_limpa_erro = 1'b0;
    n_total++; if (o_erro_timeout !== 1'b0) $display("FAIL t4_clear: erro=%b required 0", o_erro_timeout); else n_pass++;
    i_ready = 1'b1; tick(); i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_word(8'h30);
    send_word(8'h31);
    i_dados = 8'h32; i_req = 1'b1;
    tick(); tick(); tick();
    n_total++; if (o_ack !== 1'b1 || o_nivel !== 3'd3) $display("FAIL t5_pre: ack=%b nivel=%0d required 1/3", o_ack, o_nivel); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (o_ack !== 1'b0 || o_valid !== 1'b0 || o_nivel !== 3'd0 || o_num_transf !== 4'd0 || o_dados !== 8'h00)
      $display("FAIL t5_async: ack=%b valid=%b nivel=%0d num=%0d dados=%h required all 0", o_ack, o_valid, o_nivel, o_num_transf, o_dados); else n_pass++;
    i_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_num = '0;
    send_word(8'h33);
    n_total++; if (o_dados !== 8'h33 || o_nivel !== 3'd1 || o_num_transf !== 4'd1)
      $display("FAIL t5_after: dados=%h nivel=%0d num=%0d required 33/1/1", o_dados, o_nivel, o_num_transf); else n_pass++;
    i_ready = 1'b1; tick(); i_ready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    reset = 1'b1; tick(); reset = 1'b0;
    exp_num = '0;
    i_ready = 1'b1;
    for (int k = 0; k < 16; k++) send_word(8'(8'h40 + k));
    n_total++; if (o_num_transf !== 4'd0) $display("FAIL t6_wrap16: num=%0d required 0", o_num_transf); else n_pass++;
    send_word(8'h50);
    n_total++; if (o_num_transf !== 4'd1 || o_num_transf !== exp_num) $display("FAIL t6_wrap17: num=%0d required 1", o_num_transf); else n_pass++;
    i_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_backpressure();
    test_push_pop_same_cycle();
    test_timeout();
    test_reset_mid();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
